// File: rtl/serial_fa_ctrl.sv
// serial_fa_ctrl: bit-serial add/subtract controller around a single 1-bit
// full-adder cell (fa_nand). One bit pair per clock, LSB first.
// Optional build macro SERIAL_FA_OVF_EN: when defined, signed overflow is
// computed on the last bit; when undefined, ovf is tied low.

// Gate-level 1-bit full adder built only from 2-input NANDs.
module fa_nand (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic n1, n2, n3, x, n4, n5, n6;
  assign n1 = ~(a & b);
  assign n2 = ~(a & n1);
  assign n3 = ~(b & n1);
  assign x  = ~(n2 & n3);   // a ^ b
  assign n4 = ~(x & ci);
  assign n5 = ~(x & n4);
  assign n6 = ~(ci & n4);
  assign s  = ~(n5 & n6);   // a ^ b ^ ci
  assign co = ~(n1 & n4);   // a&b | (a^b)&ci
endmodule

module serial_fa_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             creg;
  logic             fs, fc;
  logic             last;

  // The one shared adder cell; operands come from the LSBs of the shifters.
  fa_nand u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (creg),
    .s  (fs),
    .co (fc)
  );

  assign last = (cnt == CW'(WIDTH-1));

`ifdef SERIAL_FA_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // Control FSM plus operand/result shifters; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      creg  <= 1'b0;
      sa    <= '0;
      sb    <= '0;
`ifdef SERIAL_FA_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            // Subtract as A + ~B + 1: invert B and seed the carry with 1.
            sb    <= sub ? ~b : b;
            creg  <= sub;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_FA_OVF_EN
            ovf_q <= 1'b0;
`endif
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum  <= {fs, sum[WIDTH-1:1]};
          creg <= fc;
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          cnt  <= cnt + 1'b1;
          if (last) begin
            cout  <= fc;
`ifdef SERIAL_FA_OVF_EN
            // creg holds the carry into the MSB while the MSB is processed.
            ovf_q <= creg ^ fc;
`endif
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_fa_ctrl.sv
// Bench for serial_fa_ctrl (WIDTH=8): arithmetic/phase model plus directed ops.
module tb_serial_fa_ctrl;
  localparam int W = 8;
`ifdef SERIAL_FA_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  serial_fa_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Model: phase 0 = idle, 1..W = computing, W+1 = done cycle.
  int           m_phase = 0;
  logic [W-1:0] m_sum = '0, p_sum = '0;
  logic         m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        int sa, sb, r;
        logic [W:0] full;
        sa = int'($signed(a)); sb = int'($signed(b));
        r  = sub ? sa - sb : sa + sb;
        full = sub ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
        p_sum  <= full[W-1:0];
        p_cout <= full[W];
        p_ovf  <= OVF_ON && (r > 127 || r < -128);
        m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
        m_phase <= 1;
      end
    end else if (m_phase == W) begin
      m_sum <= p_sum; m_cout <= p_cout; m_ovf <= p_ovf;
      m_phase <= W + 1;
    end else if (m_phase == W + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  // Compare every cycle; result fields only where they are defined.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_phase != 0);
      check("done", done, m_phase == W + 1);
      if (m_phase == 0 || m_phase == W + 1) begin
        check("sum", sum, m_sum);
        check("cout", cout, m_cout);
        check("ovf", ovf, m_ovf);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic ts,
                        input logic [W-1:0] es, input logic ec, input logic eo, input string nm);
    int lat, nb;
    bit got;
    @(negedge clk);
    a = ta; b = tb2; sub = ts; start = 1'b1;
    lat = 0; nb = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = ~ta; b = ~tb2; sub = ~ts;   // late changes must not disturb the op
      lat++;
      if (busy) nb++;
      if (done) got = 1'b1;
    end
    check({nm, "_done_seen"}, got, 1);
    check({nm, "_latency"}, lat, 9);
    check({nm, "_busy_cycles"}, nb, 9);
    check({nm, "_sum"}, sum, es);
    check({nm, "_cout"}, cout, ec);
    check({nm, "_ovf"}, ovf, eo);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;   // start together with rst is lost
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    chk_en = 1'b1;

    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "add");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "wrap");
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_ON, "sovf");
    run_op(8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, "sub_pos");
    run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_neg");
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, OVF_ON, "sub_ovf");

    // Ignored request during the 3rd compute cycle.
    @(negedge clk);
    a = 8'h35; b = 8'h4A; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12 && ndone == 0; i++) begin
      if (done) ndone++;
      if (ndone == 0) @(negedge clk);
    end
    check("ign_done_seen", ndone, 1);
    check("ign_sum", sum, 8'h7F);
    @(negedge clk);

    // Reset during the 4th compute cycle.
    @(negedge clk);
    a = 8'h35; b = 8'h4A; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_sum", sum, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mrst_no_done", ndone, 0);

    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "after_rst");

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_fa_ctrl.md
# serial_fa_ctrl

Bit-serial add/subtract controller that time-shares a single 1-bit full-adder cell (the `fa_nand` datapath) across a WIDTH-bit operation. It latches two operands on a start request, feeds one bit pair plus the registered carry into the cell per clock (LSB first), and shifts the sum bit into a result register. It reports completion with a one-cycle done pulse. It sits between a request source (FSM or testbench) and the gate-level adder cell, and replaces a WIDTH-bit ripple adder where area matters more than latency.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset; sampled on rising edge of clk.
- start  in  1  request; accepted only in IDLE.
- sub  in  1  0 = A+B, 1 = A−B; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse, result valid.
- sum  out  WIDTH  result; holds until the next accepted start or reset.
- cout  out  1  final carry out. For subtract this is the not-borrow bit: 1 means A ≥ B unsigned.
- ovf  out  1  signed overflow (see Configuration).

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE, start=1: latch a into shift register SA and b into SB.
  - If sub=1, SB is loaded with ~b.
  - Carry register loaded with sub.
  - Bit counter cleared to 0.
  - sum cleared to 0, cout and ovf cleared to 0.
  - Go to RUN.
- IDLE, start=0: hold all outputs.
- RUN, each cycle:
  - Cell inputs are SA[0], SB[0] and the carry register.
  - The cell's sum bit shifts into sum at the MSB end (shift right), so that after WIDTH shifts bit i sits at sum[i].
  - The cell's carry is written to the carry register.
  - SA and SB shift right by 1; counter increments.
  - When counter = WIDTH−1 (last bit), also capture:
    - cout ← cell carry;
    - ovf ← carry-in to MSB XOR cell carry.
  - Then go to DONE.
- DONE: done=1 for exactly one cycle; go to IDLE.
- start while busy=1 (RUN or DONE) is ignored; no queueing.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.

## Timing
Reset values (outputs and state after rst):
- state = IDLE
- busy = 0, done = 0
- sum = 0, cout = 0, ovf = 0
- counter = 0, carry register = 0

Latency and throughput:
- start sampled at edge k → RUN occupies edges k+1..k+WIDTH → done=1 during the cycle after edge k+WIDTH.
- For WIDTH=8: done is seen 9 cycles after the start edge.
- Throughput is one operation per WIDTH+2 cycles (start in IDLE, WIDTH RUN cycles, 1 DONE cycle).

Boundary conditions:
- busy rises the cycle after start is accepted and falls with the DONE→IDLE transition.
- rst in any state, including mid-RUN, returns to IDLE next edge with all reset values. The partial result is discarded and no done pulse is issued.
- rst and start in the same cycle: rst wins; the request is lost.
- Changes to a, b or sub after start has been accepted have no effect on the running operation.
- sum bits are not valid until done. Intermediate sum values during RUN are visible but undefined to consumers.

## Configuration
- Macro SERIAL_FA_OVF_EN.
- Defined: ovf is computed as described and registered with cout on the last RUN cycle. This needs one extra flop holding the carry into the MSB.
- Undefined: ovf is tied to 0, and the MSB-carry flop and its XOR are not built. The port remains present, so instantiations are identical in both builds.

## Test plan
All scenarios use WIDTH=8.
- Add, no carry: reset, then a=0x35, b=0x4A, sub=0, 1-cycle start → done pulse 9 cycles later; sum=0x7F, cout=0, ovf=0; busy high for exactly 9 cycles.
- Add with wrap: a=0xFF, b=0x01, sub=0 → sum=0x00, cout=1, ovf=0.
- Signed overflow: a=0x7F, b=0x01, sub=0 → sum=0x80, cout=0.
  - With SERIAL_FA_OVF_EN: ovf=1.
  - Without it: ovf=0.
- Subtract:
  - a=0x20, b=0x10, sub=1 → sum=0x10, cout=1.
  - a=0x10, b=0x20, sub=1 → sum=0xF0, cout=0.
  - a=0x80, b=0x01, sub=1 → sum=0x7F, ovf=1 when the macro is enabled.
- Ignored request and mid-run reset:
  - Start a=0x35, b=0x4A.
  - Pulse start with a=0xFF during the 3rd RUN cycle → ignored; result is still 0x7F.
  - Repeat, but assert rst during the 4th RUN cycle → next cycle busy=0, sum=0, no done pulse.
  - A subsequent start runs normally.
